// File: rtl/cmd_guard.sv
// Command sanitizer: accepts raw user commands, issues only legal codes as a
// strobed, held command, and locks out permanently after repeated illegal input.
//
// state  | meaning
// IDLE   | ready, waiting for in_valid
// CHECK  | captured code being classified legal/illegal
// ISSUE  | strobe cycle, cmd_out carries the command
// HOLD   | cmd_out held while the hold counter runs down
// LOCKED | refusing all commands until rst
module cmd_guard #(
   parameter int MAX_ERR     = 3,
   parameter int HOLD_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [2:0] in_cmd,
   output logic       in_ready,
   output logic [2:0] cmd_out,
   output logic       cmd_strobe,
   output logic       locked,
   output logic [2:0] err_cnt
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CHECK  = 3'd1,
      ISSUE  = 3'd2,
      HOLD   = 3'd3,
      LOCKED = 3'd4
   } state_t;

   localparam logic [2:0] MAX_ERR_L = 3'(MAX_ERR);
   localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

   // Plain vector so the unused encodings 5..7 stay representable.
   logic [2:0] r_state;
   logic [2:0] r_cap;
   logic [2:0] r_cmd_out;
   logic [2:0] r_err;
   logic [3:0] r_cnt;
   logic       r_strobe;
   logic       r_locked;

   state_t     w_state_nxt;
   logic [2:0] w_cap_nxt;
   logic [2:0] w_cmd_nxt;
   logic [2:0] w_err_nxt;
   logic [2:0] w_err_inc;
   logic [3:0] w_cnt_nxt;
   logic       w_strobe_nxt;
   logic       w_legal;

   assign w_legal   = (r_cap == 3'h3) || (r_cap == 3'h4) || (r_cap == 3'h5);
   assign w_err_inc = (r_err == 3'h7) ? 3'h7 : r_err + 3'h1;

   always_comb begin
      w_state_nxt  = IDLE;
      w_cap_nxt    = r_cap;
      w_cmd_nxt    = r_cmd_out;
      w_err_nxt    = r_err;
      w_cnt_nxt    = r_cnt;
      w_strobe_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            w_cmd_nxt = 3'h0;
            if (in_valid) begin
               w_cap_nxt   = in_cmd;
               w_state_nxt = CHECK;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         CHECK: begin
            if (w_legal) begin
               w_cmd_nxt    = r_cap;
               w_strobe_nxt = 1'b1;
               w_state_nxt  = ISSUE;
            end else begin
               w_cmd_nxt   = 3'h0;
               w_err_nxt   = w_err_inc;
               w_state_nxt = (w_err_inc == MAX_ERR_L) ? LOCKED : IDLE;
            end
         end
         ISSUE: begin
            w_cnt_nxt   = HOLD_LOAD;
            w_state_nxt = HOLD;
         end
         HOLD: begin
            if (r_cnt == 4'd0) begin
               w_cmd_nxt   = 3'h0;
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt   = r_cnt - 4'd1;
               w_state_nxt = HOLD;
            end
         end
         LOCKED: begin
            w_cmd_nxt   = 3'h0;
            w_state_nxt = LOCKED;
         end
         default: begin
            w_cmd_nxt   = 3'h0;
            w_state_nxt = LOCKED;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cap     <= 3'h0;
         r_cmd_out <= 3'h0;
         r_err     <= 3'h0;
         r_cnt     <= 4'd0;
         r_strobe  <= 1'b0;
         r_locked  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cap     <= w_cap_nxt;
         r_cmd_out <= w_cmd_nxt;
         r_err     <= w_err_nxt;
         r_cnt     <= w_cnt_nxt;
         r_strobe  <= w_strobe_nxt;
         r_locked  <= (w_state_nxt == LOCKED);
      end
   end

   assign in_ready   = (r_state == IDLE);
   assign cmd_out    = r_cmd_out;
   assign cmd_strobe = r_strobe;
   assign locked     = r_locked;
   assign err_cnt    = r_err;

endmodule

// File: tb/tb_cmd_guard.sv
// Directed bench for cmd_guard at default parameters (MAX_ERR=3, HOLD_CYCLES=2).
module tb_cmd_guard;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [2:0] in_cmd = 3'h0;
   logic       in_ready;
   logic [2:0] cmd_out;
   logic       cmd_strobe;
   logic       locked;
   logic [2:0] err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   cmd_guard dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_cmd     (in_cmd),
      .in_ready   (in_ready),
      .cmd_out    (cmd_out),
      .cmd_strobe (cmd_strobe),
      .locked     (locked),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic send(input logic [2:0] c);
      in_valid = 1'b1;
      in_cmd   = c;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_cmd = 3'h3;
      tick();
      n_checks++; if (cmd_out !== 3'h0) begin n_fail++; $display("FAIL reset_cmd_out got=%0h exp=0", cmd_out); end
      n_checks++; if (cmd_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe got=%0b exp=0", cmd_strobe); end
      n_checks++; if (err_cnt !== 3'h0) begin n_fail++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got=%0b exp=0", locked); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
      rst = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_legal_issue();
      logic [2:0] exp_cmd [5] = '{3'h0, 3'h4, 3'h4, 3'h4, 3'h0};
      logic       exp_stb [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic       exp_rdy [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      send(3'h4);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) tick();
         n_checks++; if (cmd_out !== exp_cmd[k]) begin n_fail++; $display("FAIL legal_cmd_out E%0d got=%0h exp=%0h", k, cmd_out, exp_cmd[k]); end
         n_checks++; if (cmd_strobe !== exp_stb[k]) begin n_fail++; $display("FAIL legal_strobe E%0d got=%0b exp=%0b", k, cmd_strobe, exp_stb[k]); end
         n_checks++; if (in_ready !== exp_rdy[k]) begin n_fail++; $display("FAIL legal_in_ready E%0d got=%0b exp=%0b", k, in_ready, exp_rdy[k]); end
      end
   endtask

   task automatic test_illegal_filter();
      logic [2:0] codes [2] = '{3'h6, 3'h7};
      int strobes;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         send(codes[i]);
         tick();
         n_checks++; if (err_cnt !== 3'(i + 1)) begin n_fail++; $display("FAIL illegal_err_cnt code=%0h got=%0d exp=%0d", codes[i], err_cnt, i + 1); end
         n_checks++; if (cmd_out !== 3'h0 || cmd_strobe !== 1'b0) begin n_fail++; $display("FAIL illegal_no_issue code=%0h cmd=%0h stb=%0b exp cmd=0 stb=0", codes[i], cmd_out, cmd_strobe); end
         n_checks++; if (locked !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_not_locked code=%0h locked=%0b rdy=%0b exp 0/1", codes[i], locked, in_ready); end
      end
      // A legal command afterwards still issues and leaves the count alone.
      strobes = 0;
      send(3'h5);
      for (int k = 0; k < 4; k++) begin
         tick();
         if (cmd_strobe === 1'b1) strobes++;
      end
      n_checks++; if (strobes != 1) begin n_fail++; $display("FAIL illegal_then_legal_strobes got=%0d exp=1", strobes); end
      n_checks++; if (err_cnt !== 3'h2) begin n_fail++; $display("FAIL err_cnt_cumulative got=%0d exp=2", err_cnt); end
   endtask

   task automatic test_lockout();
      do_reset();
      send(3'h0); tick();
      send(3'h1); tick();
      send(3'h6);
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early got=%0b exp=0", locked); end
      tick();
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_locked got=%0b exp=1", locked); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL lock_in_ready got=%0b exp=0", in_ready); end
      n_checks++; if (err_cnt !== 3'h3) begin n_fail++; $display("FAIL lock_err_cnt got=%0d exp=3", err_cnt); end
      in_valid = 1'b1; in_cmd = 3'h3;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_checks++; if (cmd_out !== 3'h0 || cmd_strobe !== 1'b0 || locked !== 1'b1) begin n_fail++; $display("FAIL lock_ignore cyc=%0d cmd=%0h stb=%0b locked=%0b exp 0/0/1", k, cmd_out, cmd_strobe, locked); end
      end
      in_valid = 1'b0;
      do_reset();
      n_checks++; if (locked !== 1'b0 || in_ready !== 1'b1 || err_cnt !== 3'h0) begin n_fail++; $display("FAIL lock_reset_exit locked=%0b rdy=%0b err=%0d exp 0/1/0", locked, in_ready, err_cnt); end
   endtask

   task automatic test_busy_ignore();
      logic [2:0] exp_cmd [10] = '{3'h0, 3'h5, 3'h5, 3'h5, 3'h0, 3'h0, 3'h3, 3'h3, 3'h3, 3'h0};
      logic       exp_stb [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      int strobes;
      do_reset();
      strobes = 0;
      in_valid = 1'b1; in_cmd = 3'h5;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (cmd_strobe === 1'b1) strobes++;
         n_checks++; if (cmd_out !== exp_cmd[k]) begin n_fail++; $display("FAIL busy_cmd_out cyc=%0d got=%0h exp=%0h", k, cmd_out, exp_cmd[k]); end
         n_checks++; if (cmd_strobe !== exp_stb[k]) begin n_fail++; $display("FAIL busy_strobe cyc=%0d got=%0b exp=%0b", k, cmd_strobe, exp_stb[k]); end
         if (k == 3) in_cmd = 3'h3;
         if (k == 5) in_valid = 1'b0;
      end
      n_checks++; if (strobes != 2) begin n_fail++; $display("FAIL busy_strobe_count got=%0d exp=2", strobes); end
   endtask

   task automatic test_reset_mid_hold();
      do_reset();
      send(3'h2); tick();
      send(3'h3);
      tick(); tick();
      n_checks++; if (cmd_out !== 3'h3 || err_cnt !== 3'h1) begin n_fail++; $display("FAIL midrst_setup cmd=%0h err=%0d exp 3/1", cmd_out, err_cnt); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (cmd_out !== 3'h0) begin n_fail++; $display("FAIL midrst_cmd_out got=%0h exp=0", cmd_out); end
      n_checks++; if (err_cnt !== 3'h0) begin n_fail++; $display("FAIL midrst_err_cnt got=%0d exp=0", err_cnt); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%0b exp=1", in_ready); end
      for (int k = 0; k < 3; k++) begin
         n_checks++; if (cmd_strobe !== 1'b0 || cmd_out !== 3'h0) begin n_fail++; $display("FAIL midrst_quiet cyc=%0d stb=%0b cmd=%0h exp 0/0", k, cmd_strobe, cmd_out); end
         tick();
      end
   endtask

   task automatic test_fault_state();
      logic [2:0] bad [3] = '{3'd5, 3'd6, 3'd7};
      do_reset();
      send(3'h5);
      tick(); tick();
      force dut.r_state = 3'd6;
      tick();
      release dut.r_state;
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL fault_hold_locked got=%0b exp=1", locked); end
      n_checks++; if (cmd_out !== 3'h0 || cmd_strobe !== 1'b0) begin n_fail++; $display("FAIL fault_hold_cmd cmd=%0h stb=%0b exp 0/0", cmd_out, cmd_strobe); end
      tick();
      n_checks++; if (in_ready !== 1'b0 || locked !== 1'b1) begin n_fail++; $display("FAIL fault_hold_stays rdy=%0b locked=%0b exp 0/1", in_ready, locked); end
      for (int i = 0; i < 3; i++) begin
         do_reset();
         force dut.r_state = bad[i];
         tick();
         release dut.r_state;
         in_valid = 1'b1; in_cmd = 3'h4;
         tick();
         tick();
         in_valid = 1'b0;
         n_checks++; if (locked !== 1'b1 || in_ready !== 1'b0 || cmd_out !== 3'h0 || cmd_strobe !== 1'b0) begin
            n_fail++; $display("FAIL fault_enc_%0d locked=%0b rdy=%0b cmd=%0h stb=%0b exp 1/0/0/0", bad[i], locked, in_ready, cmd_out, cmd_strobe);
         end
      end
   endtask

   initial begin
      test_reset();
      test_legal_issue();
      test_illegal_filter();
      test_lockout();
      test_busy_ignore();
      test_reset_mid_hold();
      test_fault_state();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cmd_guard.md
CMD_GUARD -- requirements
Module: cmd_guard

Interface
REQ-001 Parameter MAX_ERR, default 3: illegal commands accepted before permanent lockout (range 1..7).
REQ-002 Parameter HOLD_CYCLES, default 2: cycles cmd_out is held after the strobe cycle (range 1..15).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset:
- clk  input  1  sole clock, all state updated on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  raw user command valid
- in_cmd  input  3  raw user command code
- in_ready  output  1  block can accept a command this cycle
- cmd_out  output  3  sanitized command to downstream FSM user_input, registered
- cmd_strobe  output  1  one-cycle pulse marking a newly issued command, registered
- locked  output  1  block permanently refuses commands until rst
- err_cnt  output  3  count of illegal commands accepted, registered

Function
REQ-004 Legal command codes SHALL be exactly 3'h3, 3'h4, 3'h5; all other codes (0,1,2,6,7) are illegal.
REQ-005 cmd_out SHALL only take the values 3'h0 (NOP), 3'h3, 3'h4 or 3'h5; no other value ever appears on it.
REQ-006 FSM states SHALL be IDLE, CHECK, ISSUE, HOLD, LOCKED, in a 3-bit encoding with all 8 encodings decoded.
REQ-007 Any unused state encoding SHALL transition to LOCKED on the next edge; cmd_out=0 and cmd_strobe=0 while in it.
REQ-008 IDLE: in_ready=1; on in_valid&&in_ready, capture in_cmd into an internal register and go to CHECK; otherwise stay.
REQ-009 in_ready SHALL be 1 only in IDLE; in_valid while in_ready=0 is ignored, not queued.
REQ-010 CHECK: if the captured code is legal, go to ISSUE.
REQ-011 CHECK: if the captured code is illegal, increment err_cnt (saturating at 7); go to LOCKED if the incremented value equals MAX_ERR, else to IDLE.
REQ-012 On the CHECK->ISSUE edge, cmd_out SHALL load the captured code and cmd_strobe SHALL load 1.
REQ-013 ISSUE lasts exactly one cycle and then goes to HOLD, loading the hold counter with HOLD_CYCLES-1; cmd_strobe clears on that edge.
REQ-014 HOLD: keep cmd_out and decrement the counter each cycle; when the counter is 0, go to IDLE and load cmd_out=0 on that edge.
REQ-015 Latency: with acceptance at edge E0, cmd_strobe=1 and cmd_out=cmd for cycle E1..E2; cmd_out stays nonzero for exactly 1+HOLD_CYCLES cycles; in_ready returns at edge E2+HOLD_CYCLES.
REQ-016 An illegal command SHALL never change cmd_out or assert cmd_strobe.
REQ-017 LOCKED: locked=1, in_ready=0, cmd_out=0, cmd_strobe=0; the only exit is rst.
REQ-018 err_cnt SHALL be cumulative; legal commands never decrement or clear it; it is cleared only by rst.
REQ-019 locked SHALL be registered and assert on the same edge the FSM enters LOCKED.

Reset
REQ-020 rst=1 at a rising edge SHALL force state=IDLE, cmd_out=0, cmd_strobe=0, err_cnt=0, locked=0, the hold counter to 0 and the captured command to 0, overriding every other input.
REQ-021 In the cycle after reset, in_ready SHALL be 1.
REQ-022 rst asserted in any state, including mid-HOLD or LOCKED, SHALL abort the operation with no further strobe or nonzero cmd_out.

Verification
REQ-023 Legal issue, default parameters: in_cmd=4 accepted at E0 -> cmd_strobe=1 only in cycle E1..E2; cmd_out=4 for 3 cycles; then cmd_out=0 and in_ready=1 at E4.
REQ-024 Illegal filtering: in_cmd=6, then in_cmd=7 -> cmd_out stays 0, no strobe, err_cnt=1 then 2, locked=0.
REQ-025 Lockout: three illegal commands (0,1,6) -> locked=1 and in_ready=0 on the CHECK edge of the third; a subsequent in_cmd=3 is ignored.
REQ-026 Busy ignore: in_valid held with in_cmd=5 during ISSUE/HOLD, then in_cmd=3 -> exactly one strobe per accepted command; cmd_out never shows a value outside {0,3,4,5}.
REQ-027 Reset mid-operation: rst pulsed during HOLD with cmd_out=3 -> the next cycle shows cmd_out=0, err_cnt=0, in_ready=1 and no strobe.
REQ-028 Fault injection: force the state register to an unused encoding -> LOCKED next edge, locked=1 and cmd_out=0.
